// File: rtl/rf_wb_stage_if.sv
// Result/operand bus between the DM stage, decode and the rf_wb_stage
// register file.
//   master : drives the writeback (RW_dm, mux_ans_dm) and decode-side
//            controls (RA_id, RB_id, RW_id, stall_id, flush_id); receives
//            the ID/EX operands.
//   slave  : the register file / ID/EX boundary itself.
interface rf_wb_stage_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] RW_dm;
  logic [DATA_W-1:0] mux_ans_dm;
  logic [ADDR_W-1:0] RA_id;
  logic [ADDR_W-1:0] RB_id;
  logic [ADDR_W-1:0] RW_id;
  logic              stall_id;
  logic              flush_id;
  logic [DATA_W-1:0] A_rf;
  logic [DATA_W-1:0] B_rf;
  logic [ADDR_W-1:0] RA_rf;
  logic [ADDR_W-1:0] RB_rf;
  logic [ADDR_W-1:0] RW_rf;

  modport master (
    output RW_dm, mux_ans_dm, RA_id, RB_id, RW_id, stall_id, flush_id,
    input  A_rf, B_rf, RA_rf, RB_rf, RW_rf
  );

  modport slave (
    input  RW_dm, mux_ans_dm, RA_id, RB_id, RW_id, stall_id, flush_id,
    output A_rf, B_rf, RA_rf, RB_rf, RW_rf
  );
endinterface

// File: rtl/rf_wb_stage.sv
// Register file and writeback stage for the 8-bit pipelined processor.
// Commits the DM-stage result to the array, serves two bypassed read ports
// to decode and registers the operands/addresses into the ID/EX boundary.
// Ports:
//   clk   : pipeline clock, all state updates on posedge
//   reset : asynchronous active-high, clears the array and ID/EX registers
//   bus   : rf_wb_stage_if.slave (writeback in, decode in, ID/EX out)
// NUM_REGS must equal 2**ADDR_W.
module rf_wb_stage #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic         clk,
  input  logic         reset,
  rf_wb_stage_if.slave bus
);

  logic [DATA_W-1:0] regs_reg [NUM_REGS];

  logic              wr_en;
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  logic [DATA_W-1:0] a_rf_reg;
  logic [DATA_W-1:0] b_rf_reg;
  logic [ADDR_W-1:0] ra_rf_reg;
  logic [ADDR_W-1:0] rb_rf_reg;
  logic [ADDR_W-1:0] rw_rf_reg;

  // Destination 0 means "no write"; this also keeps entry 0 at its reset 0.
  assign wr_en = (bus.RW_dm != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (wr_en) begin
      regs_reg[bus.RW_dm] <= bus.mux_ans_dm;
    end
  end

  assign rd_addr[0] = bus.RA_id;
  assign rd_addr[1] = bus.RB_id;

  // Two identical read ports; the bypass lets decode see a result in the
  // same cycle the DM stage commits it.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
      always_comb begin
        rd_data[gi] = '0;
        if (rd_addr[gi] == '0) begin
          rd_data[gi] = '0;
        end else if (rd_addr[gi] == bus.RW_dm) begin
          rd_data[gi] = bus.mux_ans_dm;
        end else begin
          rd_data[gi] = regs_reg[rd_addr[gi]];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rf_reg  <= '0;
      b_rf_reg  <= '0;
      ra_rf_reg <= '0;
      rb_rf_reg <= '0;
      rw_rf_reg <= '0;
    end else if (bus.flush_id) begin
      // Bubble: RW=0 guarantees no downstream write.
      a_rf_reg  <= '0;
      b_rf_reg  <= '0;
      ra_rf_reg <= '0;
      rb_rf_reg <= '0;
      rw_rf_reg <= '0;
    end else if (bus.stall_id) begin
      // Held operands would go stale if their source register is written
      // while we wait, so pick up the new value as it is committed.
      if (wr_en && (bus.RW_dm == ra_rf_reg)) begin
        a_rf_reg <= bus.mux_ans_dm;
      end
      if (wr_en && (bus.RW_dm == rb_rf_reg)) begin
        b_rf_reg <= bus.mux_ans_dm;
      end
    end else begin
      a_rf_reg  <= rd_data[0];
      b_rf_reg  <= rd_data[1];
      ra_rf_reg <= bus.RA_id;
      rb_rf_reg <= bus.RB_id;
      rw_rf_reg <= bus.RW_id;
    end
  end

  assign bus.A_rf  = a_rf_reg;
  assign bus.B_rf  = b_rf_reg;
  assign bus.RA_rf = ra_rf_reg;
  assign bus.RB_rf = rb_rf_reg;
  assign bus.RW_rf = rw_rf_reg;

endmodule

// File: tb/tb_rf_wb_stage.sv
// Directed testbench for rf_wb_stage: hand-computed expected values,
// one line per comparison, one summary line at the end.
module tb_rf_wb_stage;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  rf_wb_stage_if #(.DATA_W(8), .ADDR_W(5)) bus ();

  rf_wb_stage #(.DATA_W(8), .ADDR_W(5), .NUM_REGS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance through one posedge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rw_dm, input logic [7:0] data,
                       input logic [4:0] ra, input logic [4:0] rb,
                       input logic [4:0] rw, input logic stall, input logic flush);
    bus.RW_dm      = rw_dm;
    bus.mux_ans_dm = data;
    bus.RA_id      = ra;
    bus.RB_id      = rb;
    bus.RW_id      = rw;
    bus.stall_id   = stall;
    bus.flush_id   = flush;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive(5'd0, 8'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    step();
    check("rst_A",  bus.A_rf,  8'h00);
    check("rst_B",  bus.B_rf,  8'h00);
    check("rst_RA", bus.RA_rf, 5'd0);
    check("rst_RB", bus.RB_rf, 5'd0);
    check("rst_RW", bus.RW_rf, 5'd0);
    reset = 1'b0;

    // Write r3, then read it back through the array.
    drive(5'd3, 8'h5C, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    drive(5'd0, 8'h00, 5'd3, 5'd0, 5'd12, 1'b0, 1'b0);
    step();
    check("rd_r3_A",  bus.A_rf,  8'h5C);
    check("rd_r3_B",  bus.B_rf,  8'h00);
    check("rd_r3_RA", bus.RA_rf, 5'd3);
    check("rd_r3_RW", bus.RW_rf, 5'd12);

    // Same-cycle bypass on both ports, then the array copy.
    drive(5'd7, 8'h3E, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0);
    step();
    check("byp_A", bus.A_rf, 8'h3E);
    check("byp_B", bus.B_rf, 8'h3E);
    drive(5'd0, 8'h00, 5'd7, 5'd3, 5'd0, 1'b0, 1'b0);
    step();
    check("arr_r7_A", bus.A_rf, 8'h3E);
    check("arr_r3_B", bus.B_rf, 8'h5C);

    // Register 0 reads 0 even when it is the writeback target.
    drive(5'd0, 8'hFF, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    check("r0_same_A", bus.A_rf, 8'h00);
    drive(5'd0, 8'h00, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0);
    step();
    check("r0_next_A", bus.A_rf, 8'h00);
    check("r0_next_B", bus.B_rf, 8'h3E);

    // Stall with stale-operand refresh.
    drive(5'd4, 8'h11, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    drive(5'd0, 8'h00, 5'd4, 5'd3, 5'd2, 1'b0, 1'b0);
    step();
    check("cap_A",  bus.A_rf,  8'h11);
    check("cap_RA", bus.RA_rf, 5'd4);
    drive(5'd4, 8'h99, 5'd9, 5'd9, 5'd15, 1'b1, 1'b0);
    step();
    check("stl_ref_A",  bus.A_rf,  8'h99);
    check("stl_RA",     bus.RA_rf, 5'd4);
    check("stl_RB",     bus.RB_rf, 5'd3);
    check("stl_RW",     bus.RW_rf, 5'd2);
    check("stl_hold_B", bus.B_rf,  8'h5C);
    drive(5'd6, 8'h55, 5'd9, 5'd9, 5'd15, 1'b1, 1'b0);
    step();
    check("stl_other_A", bus.A_rf, 8'h99);
    check("stl_other_B", bus.B_rf, 8'h5C);
    drive(5'd3, 8'h77, 5'd9, 5'd9, 5'd15, 1'b1, 1'b0);
    step();
    check("stl_ref_B", bus.B_rf, 8'h77);
    check("stl_keep_A", bus.A_rf, 8'h99);

    // Flush beats stall.
    drive(5'd0, 8'h00, 5'd4, 5'd6, 5'd9, 1'b1, 1'b1);
    step();
    check("fl_A",  bus.A_rf,  8'h00);
    check("fl_B",  bus.B_rf,  8'h00);
    check("fl_RA", bus.RA_rf, 5'd0);
    check("fl_RB", bus.RB_rf, 5'd0);
    check("fl_RW", bus.RW_rf, 5'd0);
    drive(5'd0, 8'h00, 5'd4, 5'd6, 5'd9, 1'b0, 1'b0);
    step();
    check("post_fl_A",  bus.A_rf,  8'h99);
    check("post_fl_B",  bus.B_rf,  8'h55);
    check("post_fl_RA", bus.RA_rf, 5'd4);
    check("post_fl_RB", bus.RB_rf, 5'd6);
    check("post_fl_RW", bus.RW_rf, 5'd9);

    // Asynchronous reset mid-run after writing r5.
    drive(5'd5, 8'hA7, 5'd4, 5'd3, 5'd1, 1'b0, 1'b0);
    step();
    check("pre_rst_A", bus.A_rf, 8'h99);
    check("pre_rst_B", bus.B_rf, 8'h77);
    #2;
    reset = 1'b1;
    #1;
    check("async_A",  bus.A_rf,  8'h00);
    check("async_B",  bus.B_rf,  8'h00);
    check("async_RA", bus.RA_rf, 5'd0);
    check("async_RW", bus.RW_rf, 5'd0);
    drive(5'd0, 8'h00, 5'd5, 5'd4, 5'd0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    step();
    check("rst_r5_A",  bus.A_rf,  8'h00);
    check("rst_r4_B",  bus.B_rf,  8'h00);
    check("rst_r5_RA", bus.RA_rf, 5'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_wb_stage.md
Name: rf_wb_stage

Overview:
- Register-file / writeback block for the 8-bit pipelined processor; the consumer end of the data-memory stage's result interface.
- Commits the DM-stage result (mux_ans_dm) to the register addressed by RW_dm.
- Serves two read ports to decode, with same-cycle write-through bypass.
- Registers the operands, source addresses and destination into the ID/EX pipeline boundary, with stall and flush control.

Parameters:
- DATA_W, 8, register and operand width
- ADDR_W, 5, register address width
- NUM_REGS, 32, number of registers; must equal 2**ADDR_W

Ports:
- clk  input  1  pipeline clock; all state updates on posedge
- reset  input  1  asynchronous, active-high; clears all state
- RW_dm  input  ADDR_W  writeback destination from DM stage; 0 = no write
- mux_ans_dm  input  DATA_W  writeback data from DM stage
- RA_id  input  ADDR_W  source A address from decode
- RB_id  input  ADDR_W  source B address from decode
- RW_id  input  ADDR_W  destination address from decode, passed to EX
- stall_id  input  1  hold the ID/EX registers
- flush_id  input  1  insert a bubble into the ID/EX registers
- A_rf  output  DATA_W  registered operand A to EX
- B_rf  output  DATA_W  registered operand B to EX
- RA_rf  output  ADDR_W  registered source A address, for the forwarding unit
- RB_rf  output  ADDR_W  registered source B address, for the forwarding unit
- RW_rf  output  ADDR_W  registered destination to EX

Behaviour:
- Storage: NUM_REGS x DATA_W array.
  - Register 0 is hardwired to 0: reads return 0 and writes are ignored.
- Reset (asynchronous, active-high):
  - All array entries clear to 0.
  - A_rf, B_rf, RA_rf, RB_rf and RW_rf clear to 0.
  - If reset asserts mid-operation, any write in the same cycle is lost.
  - First capture after deassertion is at the next posedge.
- Write: at posedge, if RW_dm != 0, array[RW_dm] <= mux_ans_dm.
- Combinational read value rdA:
  - If RA_id == 0: rdA = 0.
  - Else if RA_id == RW_dm: rdA = mux_ans_dm (write-through bypass).
  - Else: rdA = array[RA_id].
  - rdB is computed the same way from RB_id.
- ID/EX register update at posedge. Priority is reset > flush_id > stall_id > normal.
  - flush_id=1: A_rf, B_rf, RA_rf, RB_rf and RW_rf all load 0. A bubble with RW=0 causes no downstream write.
  - stall_id=1 and flush_id=0:
    - RA_rf, RB_rf and RW_rf hold.
    - A_rf and B_rf hold, except stale-operand refresh: if RW_dm != 0 and RW_dm == RA_rf, A_rf <= mux_ans_dm. Same rule for B_rf against RB_rf.
    - Both operands may refresh in the same cycle.
  - Normal: A_rf <= rdA, B_rf <= rdB, RA_rf <= RA_id, RB_rf <= RB_id, RW_rf <= RW_id.
- Latency:
  - Operand is valid at A_rf/B_rf one cycle after its address is presented.
  - A write is visible at the read ports in the same cycle via bypass, and from the array on the following cycle.
- Simultaneous events:
  - RA_id == RB_id == RW_dm: both operands receive mux_ans_dm.
  - flush_id and stall_id together: flush wins.
  - Write to register 0 together with a read of register 0: reads 0.
- No combinational path from any input to any output; all outputs are registers.

Test Plan:
- Assert reset mid-run after writing r5=8'hA7 -> all outputs 0 immediately. After release, RA_id=5 gives A_rf=0 on the next edge.
- Write r3=8'h5C (RW_dm=3). Next cycle RA_id=3, RB_id=0 -> after the edge A_rf=8'h5C, B_rf=8'h00, RA_rf=3.
- Same-cycle bypass: RW_dm=7, mux_ans_dm=8'h3E, RA_id=RB_id=7 -> after the edge A_rf=B_rf=8'h3E, and array r7=8'h3E.
- Write to r0: RW_dm=0, mux_ans_dm=8'hFF, then RA_id=0 -> A_rf=8'h00.
- Stall refresh: capture RA_rf=4 with A_rf=8'h11. Hold stall_id=1 and write RW_dm=4, 8'h99 -> A_rf becomes 8'h99 and RA_rf stays 4. Writing RW_dm=6 during the stall leaves A_rf unchanged.
- stall_id=1 and flush_id=1 with RW_id=9 -> all ID/EX outputs become 0. Next unstalled cycle captures the new decode values normally.
